// File: rtl/cgra_seq_pkg.sv
// rtl/cgra_seq_pkg.sv - shared types and default widths for the CGRA PC sequencer
package cgra_seq_pkg;

    localparam int PC_W_DEF = 12;
    localparam int VL_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        VECT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cgra_vect_counter.sv
// rtl/cgra_vect_counter.sv - vector length latch, element index counter and terminal flag
module cgra_vect_counter
    import cgra_seq_pkg::*;
#(
    parameter int VL_W = VL_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            active_i,
    input  logic            stall_i,
    input  logic [VL_W-1:0] vect_len_i,
    output logic            multi_o,
    output logic [VL_W-1:0] vect_idx_o,
    output logic            done_auto_incr_o
);

    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W-1:0] idx_q, idx_d;

    // Lengths 0 and 1 both mean a single issue, so only >1 needs the VECT state.
    assign multi_o          = (vect_len_i > VL_W'(1));
    assign done_auto_incr_o = active_i && !stall_i && (idx_q == vl_q - VL_W'(1));
    assign vect_idx_o       = idx_q;

    always_comb begin
        vl_d  = vl_q;
        idx_d = idx_q;
        if (load_i) begin
            vl_d  = vect_len_i;
            idx_d = VL_W'(1);
        end else if (active_i && !stall_i) begin
            idx_d = done_auto_incr_o ? '0 : idx_q + VL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q  <= '0;
            idx_q <= '0;
        end else begin
            vl_q  <= vl_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/cgra_pc_sequencer.sv
// rtl/cgra_pc_sequencer.sv - CGRA tile program counter sequencer with vector re-issue and BNE
module cgra_pc_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int VL_W = VL_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [PC_W-1:0] start_pc_i,
    input  logic            stall_i,
    input  logic            is_not_vect_i,
    input  logic [VL_W-1:0] vect_len_i,
    input  logic            is_bne_i,
    input  logic            flag_neq_i,
    input  logic            is_halt_i,
    input  logic [PC_W-1:0] branch_imm_i,
    output logic [PC_W-1:0] pc_o,
    output logic            instr_valid_o,
    output logic [VL_W-1:0] vect_idx_o,
    output logic            vect_active_o,
    output logic            busy_o,
    output logic            done_o
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            vect_load;
    logic            vect_multi;
    logic            done_auto_incr;

    cgra_vect_counter #(.VL_W(VL_W)) u_vect_counter (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_i           (vect_load),
        .active_i         (state_q == VECT),
        .stall_i          (stall_i),
        .vect_len_i       (vect_len_i),
        .multi_o          (vect_multi),
        .vect_idx_o       (vect_idx_o),
        .done_auto_incr_o (done_auto_incr)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        vect_load     = 1'b0;
        instr_valid_o = 1'b0;
        vect_active_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d    = start_pc_i;
                    state_d = RUN;
                end
            end
            RUN: begin
                instr_valid_o = 1'b1;
                busy_o        = 1'b1;
                // A vector instruction never branches, even with is_bne set.
                if (!stall_i) begin
                    if (is_halt_i) begin
                        state_d = DONE;
                    end else if (!is_not_vect_i && vect_multi) begin
                        vect_load = 1'b1;
                        state_d   = VECT;
                    end else if (!is_not_vect_i) begin
                        pc_d = pc_q + PC_W'(1);
                    end else if (is_bne_i && flag_neq_i) begin
                        pc_d = branch_imm_i;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            VECT: begin
                instr_valid_o = 1'b1;
                vect_active_o = 1'b1;
                busy_o        = 1'b1;
                if (done_auto_incr) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_cgra_pc_sequencer.sv
// tb/tb_cgra_pc_sequencer.sv - directed self-checking bench for cgra_pc_sequencer
module tb_cgra_pc_sequencer;

    localparam int PC_W = 12;
    localparam int VL_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] start_pc;
    logic            stall;
    logic            is_not_vect;
    logic [VL_W-1:0] vect_len;
    logic            is_bne;
    logic            flag_neq;
    logic            is_halt;
    logic [PC_W-1:0] branch_imm;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic [VL_W-1:0] vect_idx;
    logic            vect_active;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    cgra_pc_sequencer #(.PC_W(PC_W), .VL_W(VL_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .start_pc_i    (start_pc),
        .stall_i       (stall),
        .is_not_vect_i (is_not_vect),
        .vect_len_i    (vect_len),
        .is_bne_i      (is_bne),
        .flag_neq_i    (flag_neq),
        .is_halt_i     (is_halt),
        .branch_imm_i  (branch_imm),
        .pc_o          (pc),
        .instr_valid_o (instr_valid),
        .vect_idx_o    (vect_idx),
        .vect_active_o (vect_active),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present the decode fields of the instruction currently at pc.
    task automatic set_instr(input logic nv, input logic [VL_W-1:0] len, input logic bne,
                             input logic neq, input logic halt, input logic [PC_W-1:0] imm);
        is_not_vect = nv;
        vect_len    = len;
        is_bne      = bne;
        flag_neq    = neq;
        is_halt     = halt;
        branch_imm  = imm;
    endtask

    task automatic scalar();
        set_instr(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic jump(input logic [PC_W-1:0] target);
        set_instr(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, target);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_pc = '0;
        stall = 1'b0;
        scalar();
        #3;
        check_eq("rst_pc", 32'(pc), 32'h0);
        check_eq("rst_iv", 32'(instr_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_va", 32'(vect_active), 32'h0);
        check_eq("rst_idx", 32'(vect_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("idle_iv", 32'(instr_valid), 32'h0);

        // start and scalar sequence
        start = 1'b1;
        start_pc = 12'h010;
        step();
        start = 1'b0;
        check_eq("start_pc", 32'(pc), 32'h010);
        check_eq("start_iv", 32'(instr_valid), 32'h1);
        check_eq("start_busy", 32'(busy), 32'h1);
        step();
        check_eq("seq_pc1", 32'(pc), 32'h011);
        step();
        check_eq("seq_pc2", 32'(pc), 32'h012);

        // BNE taken, then back to 0x012 for not-taken
        jump(12'h005);
        step();
        check_eq("bne_taken", 32'(pc), 32'h005);
        jump(12'h012);
        step();
        set_instr(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 12'h005);
        step();
        check_eq("bne_not_taken", 32'(pc), 32'h013);

        // vector length 4; mid-vector length change must be ignored
        jump(12'h020);
        step();
        set_instr(1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 12'h000);
        check_eq("v4_idx0", 32'(vect_idx), 32'h0);
        check_eq("v4_va0", 32'(vect_active), 32'h0);
        step();
        vect_len = 8'd1;
        check_eq("v4_idx1", 32'(vect_idx), 32'h1);
        check_eq("v4_va1", 32'(vect_active), 32'h1);
        check_eq("v4_pc1", 32'(pc), 32'h020);
        step();
        check_eq("v4_idx2", 32'(vect_idx), 32'h2);
        step();
        check_eq("v4_idx3", 32'(vect_idx), 32'h3);
        check_eq("v4_pc3", 32'(pc), 32'h020);
        step();
        check_eq("v4_exit_pc", 32'(pc), 32'h021);
        check_eq("v4_exit_idx", 32'(vect_idx), 32'h0);
        check_eq("v4_exit_va", 32'(vect_active), 32'h0);

        // zero-length vector with is_bne set: single issue, no branch
        jump(12'h020);
        step();
        set_instr(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 12'h055);
        step();
        check_eq("v0_pc", 32'(pc), 32'h021);
        check_eq("v0_va", 32'(vect_active), 32'h0);

        // vector length 4 with a 2-cycle stall at index 2
        jump(12'h020);
        step();
        set_instr(1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 12'h000);
        step();
        step();
        check_eq("vs_idx2", 32'(vect_idx), 32'h2);
        stall = 1'b1;
        step();
        check_eq("vs_hold1", 32'(vect_idx), 32'h2);
        check_eq("vs_iv", 32'(instr_valid), 32'h1);
        step();
        check_eq("vs_hold2", 32'(vect_idx), 32'h2);
        check_eq("vs_pc", 32'(pc), 32'h020);
        stall = 1'b0;
        step();
        check_eq("vs_idx3", 32'(vect_idx), 32'h3);
        check_eq("vs_pc6", 32'(pc), 32'h020);
        step();
        check_eq("vs_exit_pc", 32'(pc), 32'h021);

        // wrap at top of memory; start while busy is ignored
        jump(12'hFFF);
        step();
        check_eq("pre_wrap", 32'(pc), 32'hFFF);
        scalar();
        start = 1'b1;
        start_pc = 12'h333;
        step();
        start = 1'b0;
        check_eq("wrap_pc", 32'(pc), 32'h000);

        // HALT
        jump(12'h030);
        step();
        set_instr(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 12'h000);
        step();
        scalar();
        check_eq("halt_done", 32'(done), 32'h1);
        check_eq("halt_busy", 32'(busy), 32'h0);
        check_eq("halt_iv", 32'(instr_valid), 32'h0);
        check_eq("halt_pc", 32'(pc), 32'h030);
        step();
        check_eq("idle_done", 32'(done), 32'h0);
        check_eq("idle_pc", 32'(pc), 32'h030);
        check_eq("idle_busy", 32'(busy), 32'h0);

        // stall in IDLE does not block start; then reset mid-vector
        stall = 1'b1;
        start = 1'b1;
        start_pc = 12'h020;
        step();
        start = 1'b0;
        stall = 1'b0;
        check_eq("stall_idle_pc", 32'(pc), 32'h020);
        set_instr(1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 12'h000);
        step();
        step();
        check_eq("pre_rst_idx", 32'(vect_idx), 32'h2);
        rst_n = 1'b0;
        #1;
        check_eq("arst_pc", 32'(pc), 32'h0);
        check_eq("arst_idx", 32'(vect_idx), 32'h0);
        check_eq("arst_iv", 32'(instr_valid), 32'h0);
        check_eq("arst_va", 32'(vect_active), 32'h0);
        check_eq("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_done", 32'(done), 32'h0);
        check_eq("post_rst_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
